// File: rtl/mix_columns_seq.sv
// Column-serial AES MixColumns (forward or inverse): one 32-bit column per clock,
// valid/ready on both sides, with a last-round bypass that keeps latency constant.
module mix_columns_seq #(
  parameter bit INV = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] in_state,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] out_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [1:0]   col_q, col_d;
  logic [0:127] work_q, work_d;
  logic         last_q, last_d;
  logic         out_valid_q, out_valid_d;
  logic [31:0]  col_in, col_out;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul3(input logic [7:0] x);
    return xtime(x) ^ x;
  endfunction

  // 09/0b/0d/0e are sums of x, 2x, 4x and 8x
  function automatic logic [7:0] mul_inv(input logic [7:0] x, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xtime(x);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ (k[2] ? x4 : 8'h00) ^ (k[1] ? x2 : 8'h00) ^ (k[0] ? x : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] b [4];
    for (int i = 0; i < 4; i++) begin
      a[i] = c[31 - 8*i -: 8];
    end
    for (int i = 0; i < 4; i++) begin
      if (INV) begin
        b[i] = mul_inv(a[i], 4'he) ^ mul_inv(a[(i+1)%4], 4'hb) ^
               mul_inv(a[(i+2)%4], 4'hd) ^ mul_inv(a[(i+3)%4], 4'h9);
      end else begin
        b[i] = xtime(a[i]) ^ mul3(a[(i+1)%4]) ^ a[(i+2)%4] ^ a[(i+3)%4];
      end
    end
    return {b[0], b[1], b[2], b[3]};
  endfunction

  assign col_in  = work_q[{col_q, 5'b00000} +: 32];
  assign col_out = last_q ? col_in : mix_col(col_in);

  // in_ready follows out_ready in DONE so a new state can enter on the output edge
  assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign out_valid = out_valid_q;
  assign out_state = work_q;

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    work_d      = work_q;
    last_d      = last_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = in_state;
          last_d  = in_last;
          col_d   = 2'd0;
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        work_d[{col_q, 5'b00000} +: 32] = col_out;
        col_d = col_q + 2'd1;
        if (col_q == 2'd3) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
        end else begin
          state_d = BUSY;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (in_valid) begin
            work_d  = in_state;
            last_d  = in_last;
            col_d   = 2'd0;
            state_d = BUSY;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d     = IDLE;
        col_d       = 2'd0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      col_q       <= 2'd0;
      work_q      <= 128'h0;
      last_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      work_q      <= work_d;
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_mix_columns_seq.sv
// Scoreboard bench for mix_columns_seq: forward and inverse instances, directed
// FIPS-197 vectors, bypass, backpressure, back-to-back and mid-operation reset.
module tb_mix_columns_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         f_in_valid, f_in_ready, f_in_last, f_out_valid, f_out_ready;
  logic [0:127] f_in_state, f_out_state;
  logic         i_in_valid, i_in_ready, i_in_last, i_out_valid, i_out_ready;
  logic [0:127] i_in_state, i_out_state;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [0:127] f_exp_q [$];
  int           f_acc_q [$];
  logic [0:127] i_exp_q [$];
  int           i_acc_q [$];
  bit           f_seen = 1'b0;
  bit           i_seen = 1'b0;

  localparam logic [0:127] FIPS_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [0:127] FIPS_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;
  localparam logic [0:127] COL_IN   = 128'hdb135345f20a225c010101012d26314c;
  localparam logic [0:127] COL_OUT  = 128'h8e4da1bc9fdc589d010101014d7ebdf8;
  localparam logic [0:127] BYP      = 128'h00112233445566778899aabbccddeeff;

  mix_columns_seq #(.INV(1'b0)) dut_fwd (
    .clk(clk), .rst(rst),
    .in_valid(f_in_valid), .in_ready(f_in_ready), .in_state(f_in_state), .in_last(f_in_last),
    .out_valid(f_out_valid), .out_ready(f_out_ready), .out_state(f_out_state)
  );

  mix_columns_seq #(.INV(1'b1)) dut_inv (
    .clk(clk), .rst(rst),
    .in_valid(i_in_valid), .in_ready(i_in_ready), .in_state(i_in_state), .in_last(i_in_last),
    .out_valid(i_out_valid), .out_ready(i_out_ready), .out_state(i_out_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Forward monitor: latency on first valid cycle, data on the output handshake
  always @(negedge clk) begin
    #2;
    if (rst) begin
      f_seen = 1'b0;
    end else begin
      if (f_out_valid && !f_seen) begin
        f_seen = 1'b1;
        if (f_acc_q.size() == 0) begin
          check("fwd_unexpected_valid", 128'd1, 128'd0);
        end else begin
          check("fwd_latency", 128'(cyc - f_acc_q[0]), 128'd4);
        end
      end
      if (f_out_valid && f_out_ready && f_exp_q.size() != 0) begin
        check("fwd_data", f_out_state, f_exp_q.pop_front());
        void'(f_acc_q.pop_front());
        f_seen = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    #2;
    if (rst) begin
      i_seen = 1'b0;
    end else begin
      if (i_out_valid && !i_seen) begin
        i_seen = 1'b1;
        if (i_acc_q.size() == 0) begin
          check("inv_unexpected_valid", 128'd1, 128'd0);
        end else begin
          check("inv_latency", 128'(cyc - i_acc_q[0]), 128'd4);
        end
      end
      if (i_out_valid && i_out_ready && i_exp_q.size() != 0) begin
        check("inv_data", i_out_state, i_exp_q.pop_front());
        void'(i_acc_q.pop_front());
        i_seen = 1'b0;
      end
    end
  end

  // Called just after a negedge; returns at the negedge following the accepting edge.
  task automatic send(input bit inv, input logic [0:127] st, input logic last,
                      input logic [0:127] exp);
    int n = 0;
    if (inv) begin
      i_in_state = st; i_in_last = last; i_in_valid = 1'b1;
    end else begin
      f_in_state = st; f_in_last = last; f_in_valid = 1'b1;
    end
    #1;
    while ((inv ? !i_in_ready : !f_in_ready) && n < 40) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 40) begin
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 want in_ready=1 within 40 cycles");
    end else if (inv) begin
      i_exp_q.push_back(exp); i_acc_q.push_back(cyc + 1);
    end else begin
      f_exp_q.push_back(exp); f_acc_q.push_back(cyc + 1);
    end
    @(negedge clk);
    if (inv) i_in_valid = 1'b0;
    else f_in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((f_exp_q.size() != 0 || i_exp_q.size() != 0) && n < 200) begin
      @(negedge clk); #3;
      n++;
    end
    check("drain_timeout", 128'(n >= 200), 128'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    f_in_valid = 1'b0; f_in_last = 1'b0; f_in_state = '0; f_out_ready = 1'b1;
    i_in_valid = 1'b0; i_in_last = 1'b0; i_in_state = '0; i_out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", 128'(f_out_valid), 128'd0);
    check("rst_in_ready", 128'(f_in_ready), 128'd1);
    check("rst_out_state", f_out_state, 128'h0);
    @(negedge clk);

    // Inverse instance, plus its own bypass
    send(1'b1, FIPS_OUT, 1'b0, FIPS_IN);
    send(1'b1, COL_OUT, 1'b0, COL_IN);
    send(1'b1, BYP, 1'b1, BYP);
    drain();
    @(negedge clk);

    // Backpressure, then back-to-back entry on the output edge
    f_out_ready = 1'b0;
    send(1'b0, FIPS_IN, 1'b0, FIPS_OUT);
    n = 0;
    #1;
    while (!f_out_valid && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    check("bp_valid_timeout", 128'(n >= 20), 128'd0);
    repeat (3) begin
      @(negedge clk); #1;
      check("bp_out_state", f_out_state, FIPS_OUT);
      check("bp_in_ready", 128'(f_in_ready), 128'd0);
      check("bp_out_valid", 128'(f_out_valid), 128'd1);
    end
    @(negedge clk);
    f_out_ready = 1'b1;
    send(1'b0, COL_IN, 1'b0, COL_OUT);
    #1;
    check("b2b_out_valid_dropped", 128'(f_out_valid), 128'd0);
    check("b2b_in_ready_busy", 128'(f_in_ready), 128'd0);
    check("b2b_pending", 128'(f_exp_q.size()), 128'd1);
    @(negedge clk);
    send(1'b0, BYP, 1'b1, BYP);
    drain();
    @(negedge clk);

    // Reset with col==2 of an in-flight state
    send(1'b0, FIPS_IN, 1'b0, FIPS_OUT);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    f_exp_q.delete();
    f_acc_q.delete();
    #1;
    check("midrst_out_valid", 128'(f_out_valid), 128'd0);
    check("midrst_out_state", f_out_state, 128'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("postrst_in_ready", 128'(f_in_ready), 128'd1);
    check("postrst_out_valid", 128'(f_out_valid), 128'd0);
    @(negedge clk);
    send(1'b0, COL_IN, 1'b0, COL_OUT);
    send(1'b0, FIPS_IN, 1'b0, FIPS_OUT);
    drain();
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
